// File: rtl/morse_decoder.sv
// ---------------------------------------------------------------------------
// morse_decoder
//
// Turns a stream of Morse symbols (dot, dash, letter gap, word gap) into
// ASCII characters and queues them in a small show-ahead FIFO.
//
// Parameters
//   FIFO_DEPTH : character FIFO depth (power of two, >= 2)
//   MAX_ELEMS  : longest dot/dash run kept per character (>= 5)
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   arst_n     : asynchronous active-low reset
//   sym_valid  : sym carries a symbol this cycle
//   sym        : 00 dot, 01 dash, 10 letter gap, 11 word gap
//   sym_ready  : symbol is accepted this cycle (low while a space is emitted)
//   read_en    : pop the FIFO head
//   ascii_out  : FIFO head character, 0x00 when empty
//   empty      : FIFO holds no characters
//   full       : FIFO holds FIFO_DEPTH characters
//   overflow   : sticky, a character was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module morse_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_ELEMS  = 6
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       sym_valid,
  input  logic [1:0] sym,
  output logic       sym_ready,
  input  logic       read_en,
  output logic [7:0] ascii_out,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(MAX_ELEMS + 1);

  localparam logic [0:0] ST_ACCUM      = 1'b0;
  localparam logic [0:0] ST_EMIT_SPACE = 1'b1;

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_LGAP = 2'b10;
  localparam logic [1:0] SYM_WGAP = 2'b11;

  localparam logic [7:0] CH_SPACE   = 8'h20;
  localparam logic [7:0] CH_UNKNOWN = 8'h3F;

  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_ELEMS);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  logic [0:0]           state_q, state_d;
  logic [LW-1:0]        len_q, len_d;
  logic [MAX_ELEMS-1:0] code_q, code_d;
  logic                 too_long_q, too_long_d;
  logic                 last_space_q, last_space_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           mem_q [FIFO_DEPTH];

  logic                 push_req;
  logic                 push_eff;
  logic [7:0]           push_char;
  logic                 wr_en;
  logic                 rd_en;

  // The code register holds the oldest element in its highest used bit, so a
  // character of length L is identified by {L, code[L-1:0]}. Only lengths 1..5
  // have ITU assignments; anything longer, or any stray bit above bit 4, is
  // unknown. Bits above len are always zero because code is cleared per
  // character.
  function automatic logic [7:0] decode_char(input logic [LW-1:0]        len,
                                             input logic [MAX_ELEMS-1:0] code);
    logic [7:0] ch;
    logic [2:0] l3;
    logic       hi;
    hi = 1'b0;
    for (int i = 5; i < MAX_ELEMS; i++) hi = hi | code[i];
    l3 = (len > LW'(5) || hi) ? 3'd0 : len[2:0];
    case ({l3, code[4:0]})
      8'b001_00000: ch = 8'h45; // E .
      8'b001_00001: ch = 8'h54; // T -
      8'b010_00000: ch = 8'h49; // I ..
      8'b010_00001: ch = 8'h41; // A .-
      8'b010_00010: ch = 8'h4E; // N -.
      8'b010_00011: ch = 8'h4D; // M --
      8'b011_00000: ch = 8'h53; // S ...
      8'b011_00001: ch = 8'h55; // U ..-
      8'b011_00010: ch = 8'h52; // R .-.
      8'b011_00011: ch = 8'h57; // W .--
      8'b011_00100: ch = 8'h44; // D -..
      8'b011_00101: ch = 8'h4B; // K -.-
      8'b011_00110: ch = 8'h47; // G --.
      8'b011_00111: ch = 8'h4F; // O ---
      8'b100_00000: ch = 8'h48; // H ....
      8'b100_00001: ch = 8'h56; // V ...-
      8'b100_00010: ch = 8'h46; // F ..-.
      8'b100_00100: ch = 8'h4C; // L .-..
      8'b100_00110: ch = 8'h50; // P .--.
      8'b100_00111: ch = 8'h4A; // J .---
      8'b100_01000: ch = 8'h42; // B -...
      8'b100_01001: ch = 8'h58; // X -..-
      8'b100_01010: ch = 8'h43; // C -.-.
      8'b100_01011: ch = 8'h59; // Y -.--
      8'b100_01100: ch = 8'h5A; // Z --..
      8'b100_01101: ch = 8'h51; // Q --.-
      8'b101_00000: ch = 8'h35; // 5
      8'b101_00001: ch = 8'h34; // 4
      8'b101_00011: ch = 8'h33; // 3
      8'b101_00111: ch = 8'h32; // 2
      8'b101_01111: ch = 8'h31; // 1
      8'b101_11111: ch = 8'h30; // 0
      8'b101_10000: ch = 8'h36; // 6
      8'b101_11000: ch = 8'h37; // 7
      8'b101_11100: ch = 8'h38; // 8
      8'b101_11110: ch = 8'h39; // 9
      default:      ch = CH_UNKNOWN;
    endcase
    return ch;
  endfunction

  // Symbol handling: accumulate elements, and on a gap decide what character
  // (if any) is pushed this edge. A word gap after a letter defers its space
  // to the single EMIT_SPACE cycle that follows.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    code_d       = code_q;
    too_long_d   = too_long_q;
    push_req     = 1'b0;
    push_char    = CH_SPACE;

    if (state_q == ST_EMIT_SPACE) begin
      state_d  = ST_ACCUM;
      push_req = 1'b1;
      push_char = CH_SPACE;
    end else if (sym_valid) begin
      case (sym)
        SYM_DOT, SYM_DASH: begin
          if (len_q < LEN_MAX) begin
            code_d = {code_q[MAX_ELEMS-2:0], sym[0]};
            len_d  = len_q + LW'(1);
          end else begin
            too_long_d = 1'b1;
          end
        end
        SYM_LGAP, SYM_WGAP: begin
          if (len_q != '0) begin
            push_req   = 1'b1;
            push_char  = too_long_q ? CH_UNKNOWN : decode_char(len_q, code_q);
            len_d      = '0;
            code_d     = '0;
            too_long_d = 1'b0;
            if (sym == SYM_WGAP) state_d = ST_EMIT_SPACE;
          end else if (sym == SYM_WGAP) begin
            push_req  = 1'b1;
            push_char = CH_SPACE;
          end
        end
        default: ;
      endcase
    end
  end

  // Consecutive spaces collapse into one: a space push right after another
  // space is swallowed before it ever reaches the FIFO.
  always_comb begin
    push_eff     = push_req && !(push_char == CH_SPACE && last_space_q);
    last_space_d = last_space_q;
    if (push_eff) last_space_d = (push_char == CH_SPACE);
  end

  // FIFO bookkeeping. A pop while full frees the slot the push then uses, so
  // push and pop in the same cycle both proceed even when full.
  always_comb begin
    rd_en      = read_en && (count_q != '0);
    wr_en      = push_eff && ((count_q != CNT_FULL) || rd_en);
    overflow_d = overflow_q | (push_eff & ~wr_en);
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr_en && !rd_en) count_d = count_q + (AW+1)'(1);
    else if (!wr_en && rd_en) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_ACCUM;
      len_q        <= '0;
      code_q       <= '0;
      too_long_q   <= 1'b0;
      last_space_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      code_q       <= code_d;
      too_long_q   <= too_long_d;
      last_space_q <= last_space_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_char;
  end

  assign sym_ready = (state_q == ST_ACCUM);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign overflow  = overflow_q;
  assign ascii_out = empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: output character FIFO depth; power of two, minimum 2.
REQ-002 Parameter MAX_ELEMS, default 6: maximum dots/dashes per character; minimum 5.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port arst_n, input, 1: asynchronous active-low reset.
REQ-005 Port sym_valid, input, 1: sym carries a symbol this cycle.
REQ-006 Port sym, input, 2: symbol code. 00 = dot, 01 = dash, 10 = letter gap, 11 = word gap.
REQ-007 Port sym_ready, output, 1: block accepts a symbol this cycle.
REQ-008 Port read_en, input, 1: pop the FIFO head.
REQ-009 Port ascii_out, output, 8: FIFO head character, show-ahead.
REQ-010 Port empty, output, 1: FIFO holds zero entries.
REQ-011 Port full, output, 1: FIFO holds FIFO_DEPTH entries.
REQ-012 Port overflow, output, 1: sticky flag; a character was dropped.

Function
REQ-013 A symbol SHALL be accepted only in a cycle where sym_valid=1 and sym_ready=1; any other sym_valid cycle has no effect.
REQ-014 The FSM SHALL have states ACCUM and EMIT_SPACE; sym_ready=1 in ACCUM, 0 in EMIT_SPACE.
REQ-015 Accepted dot/dash with len<MAX_ELEMS SHALL do: code <= {code[MAX_ELEMS-2:0], bit}, with dash=1 and dot=0 (newest element at bit 0), and len <= len+1.
REQ-016 Accepted dot/dash with len==MAX_ELEMS SHALL leave code and len unchanged and set too_long.
REQ-017 Accepted letter gap with len>0 SHALL push one character into the FIFO in the same clock edge, then clear len, code and too_long.
REQ-018 The pushed character SHALL be the ITU Morse match for (len, code) over A-Z (uppercase, 0x41-0x5A) and 0-9 (0x30-0x39).
REQ-019 Any (len, code) without a match, or any character with too_long set, SHALL push 0x3F ('?').
REQ-020 Accepted letter gap with len==0 SHALL have no effect.
REQ-021 Accepted word gap with len>0 SHALL push the decoded character as in REQ-017 and move the FSM to EMIT_SPACE.
REQ-022 EMIT_SPACE SHALL last exactly one cycle: push 0x20, then return to ACCUM.
REQ-023 Accepted word gap with len==0 SHALL push 0x20 in the same cycle and remain in ACCUM.
REQ-024 Flag last_space SHALL be set on every 0x20 push and cleared on every non-space push.
REQ-025 Any 0x20 push attempted while last_space=1 SHALL be suppressed; in that case the word gap of REQ-021/023 still runs its FSM transitions, but no space enters the FIFO.
REQ-026 FIFO write and read in the same cycle SHALL both take effect, including when full; the count is unchanged.
REQ-027 A push while full with no simultaneous read SHALL drop the character and set overflow.
REQ-028 read_en while empty SHALL be ignored and SHALL NOT corrupt the pointers.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the count register SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-030 ascii_out SHALL equal the memory entry at the read pointer when empty=0, and 0x00 when empty=1.
REQ-031 Latency: a character pushed on edge N SHALL be visible on ascii_out with empty=0 after edge N.
REQ-032 For a word gap with a pending letter, the letter SHALL appear after edge N and the space after edge N+1.

Reset
REQ-033 While arst_n=0, the block SHALL immediately set: FSM=ACCUM, len=0, code=0, too_long=0, last_space=1, pointers=0, count=0.
REQ-034 While arst_n=0, the outputs SHALL be: sym_ready=1, ascii_out=0x00, empty=1, full=0, overflow=0.
REQ-035 FIFO memory contents need not be reset.
REQ-036 Reset asserted mid-character or in EMIT_SPACE SHALL discard the partial character and any pending space.
REQ-037 overflow SHALL clear only on reset.

Verification
REQ-038 dot, dash, letter gap -> after 1 cycle: empty=0, ascii_out=0x41 ('A'); read_en for 1 cycle -> empty=1, ascii_out=0x00.
REQ-039 dash,dot,dot,dot, word gap -> 0x42 after edge N and 0x20 after edge N+1; sym_ready=0 for one cycle; a second word gap -> no extra space pushed.
REQ-040 Seven dots, letter gap -> single 0x3F pushed; dot,dot,dash,dash, letter gap (unassigned code) -> 0x3F.
REQ-041 Reset release, then word gap first -> nothing pushed; letter gap alone -> nothing pushed.
REQ-042 Nine 'E' characters (dot, letter gap) with no reads at FIFO_DEPTH=8 -> full=1 after the 8th, overflow=1 after the 9th, 8 entries of 0x45 read back; push plus read_en while full -> count stays 8.
REQ-043 arst_n pulsed low after dash, dash -> all outputs at reset values; then dot, letter gap -> 0x45 ('E'), not a corrupted code.
